// File: rtl/led_mode_pkg.sv
// Shared constants for the LED mode player.
// Mode encodings, index width and PWM width.
package led_mode_pkg;

  localparam int IDX_W = 3;
  localparam int PWM_W = 8;

  localparam logic [IDX_W-1:0] MODE_OFF    = 3'd0;
  localparam logic [IDX_W-1:0] MODE_ON     = 3'd1;
  localparam logic [IDX_W-1:0] MODE_BLINK  = 3'd2;
  localparam logic [IDX_W-1:0] MODE_RUN_L  = 3'd3;
  localparam logic [IDX_W-1:0] MODE_RUN_R  = 3'd4;
  localparam logic [IDX_W-1:0] MODE_COUNT  = 3'd5;
  localparam logic [IDX_W-1:0] MODE_PINGPG = 3'd6;
  localparam logic [IDX_W-1:0] MODE_BREATH = 3'd7;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: counts 0..N-1 and flags tick on N-1.
// Ports: sys_clk, reset_n (async low), clr (restart at 0), tick.
module led_tick_gen #(
  parameter int N = 4
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  // A restart in the same cycle swallows the tick.
  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/led_mode_player.sv
// LED mode player: index picks one of 8 display patterns.
// Ports: sys_clk, reset_n, index[2:0] in; led[LED_W-1:0], mode_chg out.
module led_mode_player
  import led_mode_pkg::*;
#(
  parameter int LED_W      = 8,
  parameter int STEP_CNT   = 20_000_000,
  parameter int BREATH_CNT = 390_625
) (
  input  logic             sys_clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] index,
  output logic [LED_W-1:0] led,
  output logic             mode_chg
);

  localparam logic [LED_W-1:0] ONES = '1;
  localparam logic [LED_W-1:0] ONE  = LED_W'(1);
  localparam logic [PWM_W-1:0] DMAX = '1;
  localparam logic [PWM_W-1:0] DTOP = DMAX - PWM_W'(1);
  localparam logic [PWM_W-1:0] DLOW = PWM_W'(1);

  logic [IDX_W-1:0] idx_q;
  logic             chg;
  logic             step_tick;
  logic             breath_tick;

  logic [LED_W-1:0] shift;
  logic             dir_left;
  logic [LED_W-1:0] cnt;
  logic             phase;
  logic [PWM_W-1:0] duty;
  logic             ramp_up;
  logic [PWM_W-1:0] pwm_cnt;
  logic [LED_W-1:0] led_nxt;

  assign chg = (index != idx_q);

  led_tick_gen #(
    .N(STEP_CNT)
  ) u_step (
    .sys_clk(sys_clk),
    .reset_n(reset_n),
    .clr    (chg),
    .tick   (step_tick)
  );

  led_tick_gen #(
    .N(BREATH_CNT)
  ) u_breath (
    .sys_clk(sys_clk),
    .reset_n(reset_n),
    .clr    (chg),
    .tick   (breath_tick)
  );

  // Only the active mode's state advances; everything
  // else sits at its reset value until selected.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q    <= MODE_OFF;
      mode_chg <= 1'b0;
      shift    <= ONE;
      dir_left <= 1'b1;
      cnt      <= '0;
      phase    <= 1'b0;
      duty     <= '0;
      ramp_up  <= 1'b1;
      pwm_cnt  <= '0;
    end else begin
      mode_chg <= chg;
      if (chg) begin
        idx_q    <= index;
        shift    <= ONE;
        dir_left <= 1'b1;
        cnt      <= '0;
        phase    <= 1'b0;
        duty     <= '0;
        ramp_up  <= 1'b1;
        pwm_cnt  <= '0;
      end else begin
        unique case (idx_q)
          MODE_OFF,
          MODE_ON: ;
          MODE_BLINK: begin
            if (step_tick) phase <= ~phase;
          end
          MODE_RUN_L: begin
            if (step_tick)
              shift <= {shift[LED_W-2:0],
                        shift[LED_W-1]};
          end
          MODE_RUN_R: begin
            if (step_tick)
              shift <= {shift[0],
                        shift[LED_W-1:1]};
          end
          MODE_COUNT: begin
            if (step_tick) cnt <= cnt + ONE;
          end
          MODE_PINGPG: begin
            // Turn around when the lit bit is about
            // to land on an end position.
            if (step_tick) begin
              if (dir_left) begin
                shift <= shift << 1;
                if (shift[LED_W-2]) dir_left <= 1'b0;
              end else begin
                shift <= shift >> 1;
                if (shift[1]) dir_left <= 1'b1;
              end
            end
          end
          MODE_BREATH: begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (breath_tick) begin
              if (ramp_up) begin
                duty <= duty + PWM_W'(1);
                if (duty == DTOP) ramp_up <= 1'b0;
              end else begin
                duty <= duty - PWM_W'(1);
                if (duty == DLOW) ramp_up <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    led_nxt = '0;
    unique case (idx_q)
      MODE_OFF:    led_nxt = '0;
      MODE_ON:     led_nxt = ONES;
      MODE_BLINK:  led_nxt = phase ? ONES : '0;
      MODE_RUN_L,
      MODE_RUN_R,
      MODE_PINGPG: led_nxt = shift;
      MODE_COUNT:  led_nxt = cnt;
      MODE_BREATH: led_nxt = (pwm_cnt < duty) ? ONES : '0;
      default:     led_nxt = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      led <= '0;
    end else begin
      led <= led_nxt;
    end
  end

endmodule

// File: tb/tb_led_mode_player.sv
// Self-checking bench for led_mode_player.
// Small prescalers; model derives patterns from elapsed cycles.
module tb_led_mode_player;

  localparam int LW = 8;
  localparam int SC = 4;
  localparam int BC = 2;

  logic          sys_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    index = 3'd0;
  logic [LW-1:0] led;
  logic          mode_chg;

  int         total = 0;
  int         bad = 0;
  logic [2:0] cur = 3'd0;

  always #5 sys_clk = ~sys_clk;

  led_mode_player #(
    .LED_W     (LW),
    .STEP_CNT  (SC),
    .BREATH_CNT(BC)
  ) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .index   (index),
    .led     (led),
    .mode_chg(mode_chg)
  );

  // Expected led j edges after the accepting edge (j>=1).
  function automatic logic [7:0] exp_led(input int m, input int j);
    int k;
    int s;
    int r;
    int d;
    k = j - 1;
    s = k / SC;
    case (m)
      0: return 8'h00;
      1: return 8'hFF;
      2: return (s % 2 == 1) ? 8'hFF : 8'h00;
      3: return 8'(1 << (s % 8));
      4: return 8'(1 << ((8 - s % 8) % 8));
      5: return 8'(s % 256);
      6: begin
        r = s % 14;
        return 8'(1 << ((r <= 7) ? r : 14 - r));
      end
      default: begin
        r = (k / BC) % 510;
        d = (r <= 255) ? r : 510 - r;
        return ((k % 256) < d) ? 8'hFF : 8'h00;
      end
    endcase
  endfunction

  task automatic run_mode(input logic [2:0] m, input int cycles);
    logic [7:0] e;
    index = m;
    @(negedge sys_clk);
    total++;
    if (mode_chg !== 1'b1) begin
      bad++;
      $display("FAIL chg_pulse m=%0d got=%b want=1", m, mode_chg);
    end
    cur = m;
    for (int j = 1; j <= cycles; j++) begin
      @(negedge sys_clk);
      e = exp_led(int'(m), j);
      total++;
      if (led !== e) begin
        bad++;
        $display("FAIL led m=%0d j=%0d got=%h want=%h", m, j, led, e);
      end
      if (j == 1) begin
        total++;
        if (mode_chg !== 1'b0) begin
          bad++;
          $display("FAIL chg_width m=%0d got=%b want=0", m, mode_chg);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    index = 3'd0;
    repeat (3) @(negedge sys_clk);
    total++;
    if (led !== 8'h00 || mode_chg !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got=%h/%b want=00/0", led, mode_chg);
    end
    reset_n = 1'b1;
    cur = 3'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      total++;
      if (led !== 8'h00 || mode_chg !== 1'b0) begin
        bad++;
        $display("FAIL post_reset i=%0d got=%h/%b want=00/0", i, led, mode_chg);
      end
    end
  endtask

  task automatic test_run_left();
    run_mode(3'd3, 40);
  endtask

  task automatic test_run_right();
    run_mode(3'd4, 40);
  endtask

  task automatic test_pingpong();
    run_mode(3'd6, 64);
  endtask

  task automatic test_blink_count();
    run_mode(3'd2, 10);
    run_mode(3'd5, 1040);
  endtask

  task automatic test_breath();
    run_mode(3'd7, 1100);
  endtask

  task automatic test_async_reset();
    run_mode(3'd3, 10);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (led !== 8'h00 || mode_chg !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got=%h/%b want=00/0", led, mode_chg);
    end
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    cur = 3'd0;
    run_mode(3'd3, 12);
  endtask

  task automatic test_random();
    logic [2:0] m;
    for (int it = 0; it < 12; it++) begin
      do m = 3'($urandom_range(0, 7)); while (m == cur);
      run_mode(m, int'($urandom_range(2, 60)));
    end
  endtask

  initial begin
    test_reset();
    test_run_left();
    test_run_right();
    test_pingpong();
    test_blink_count();
    test_breath();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
